// File: rtl/vga_timing_gen_param.sv
// rtl/vga_timing_gen_param.sv - parametrised VGA timing generator with pixel enable, sync polarity and frame counter
// (hc,vc) hold the next position to present; every output is a registered decode of that pair.
module vga_timing_gen_param #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CW       = 10,
   parameter int FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   output logic               hs,
   output logic               vs,
   output logic [CW-1:0]      x,
   output logic [CW-1:0]      y,
   output logic               active,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       (64'd1 << CW) <= 64'(MAX_TOTAL - 1)) begin : g_param_check
      $error("vga_timing_gen_param: illegal timing parameters");
   end

   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic          HS_ON    = (HS_POL != 0);
   localparam logic          VS_ON    = (VS_POL != 0);

   logic [CW-1:0]      hc_q, hc_d;
   logic [CW-1:0]      vc_q, vc_d;
   logic [CW-1:0]      x_q, x_d;
   logic [CW-1:0]      y_q, y_d;
   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic               act_q, act_d;
   logic               ls_q, ls_d;
   logic               fs_q, fs_d;
   logic [FRAME_W-1:0] fcnt_q, fcnt_d;

   logic h_sync_win;
   logic v_sync_win;

   assign h_sync_win = (hc_q >= HS_START) && (hc_q < HS_END);
   assign v_sync_win = (vc_q >= VS_START) && (vc_q < VS_END);

   always_comb begin
      hc_d   = hc_q;
      vc_d   = vc_q;
      x_d    = x_q;
      y_d    = y_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      act_d  = act_q;
      fcnt_d = fcnt_q;
      // strobes drop on every non-tick clock so they stay one clk wide
      ls_d   = 1'b0;
      fs_d   = 1'b0;
      if (pix_en) begin
         x_d   = hc_q;
         y_d   = vc_q;
         act_d = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
         hs_d  = h_sync_win ? HS_ON : ~HS_ON;
         vs_d  = v_sync_win ? VS_ON : ~VS_ON;
         ls_d  = (hc_q == '0);
         fs_d  = (hc_q == '0) && (vc_q == '0);
         if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
               vc_d   = '0;
               fcnt_d = fcnt_q + FRAME_W'(1);
            end else begin
               vc_d = vc_q + CW'(1);
            end
         end else begin
            hc_d = hc_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hc_q   <= '0;
         vc_q   <= '0;
         x_q    <= '0;
         y_q    <= '0;
         hs_q   <= ~HS_ON;
         vs_q   <= ~VS_ON;
         act_q  <= 1'b0;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
         fcnt_q <= '0;
      end else begin
         hc_q   <= hc_d;
         vc_q   <= vc_d;
         x_q    <= x_d;
         y_q    <= y_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         act_q  <= act_d;
         ls_q   <= ls_d;
         fs_q   <= fs_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign hs          = hs_q;
   assign vs          = vs_q;
   assign x           = x_q;
   assign y           = y_q;
   assign active      = act_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// tb/tb_vga_timing_gen_param.sv - scoreboard bench: default 640x480 mode and a tiny positive-polarity mode
module tb_vga_timing_gen_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, pen_a, rst_b, pen_b;
   logic       hs_a, vs_a, act_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic [7:0] fc_a;
   logic       hs_b, vs_b, act_b, ls_b, fs_b;
   logic [3:0] x_b, y_b;
   logic [1:0] fc_b;

   vga_timing_gen_param u_dut_a (
      .clk(clk), .rst(rst_a), .pix_en(pen_a),
      .hs(hs_a), .vs(vs_a), .x(x_a), .y(y_a), .active(act_a),
      .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_timing_gen_param #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .CW(4), .FRAME_W(2)
   ) u_dut_b (
      .clk(clk), .rst(rst_b), .pix_en(pen_b),
      .hs(hs_b), .vs(vs_b), .x(x_b), .y(y_b), .active(act_b),
      .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
   );

   typedef struct {
      int hs; int vs; int act; int ls; int fs; int x; int y; int fc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb, pa, pb;
   int   ha, va, fca, hb, vb, fcb;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic void model_step(
      input int hac, hfp, hsy, hbp, vac, vfp, vsy, vbp, hpol, vpol, fw,
      input logic r, pe,
      inout int h, inout int v, inout int fc, inout exp_t e);
      int ht, vt;
      ht = hac + hfp + hsy + hbp;
      vt = vac + vfp + vsy + vbp;
      if (r) begin
         h = 0; v = 0; fc = 0;
         e.x = 0; e.y = 0; e.act = 0; e.ls = 0; e.fs = 0; e.fc = 0;
         e.hs = 1 - hpol; e.vs = 1 - vpol;
      end else if (pe) begin
         e.x   = h;
         e.y   = v;
         e.act = (h < hac && v < vac) ? 1 : 0;
         e.hs  = (h >= hac + hfp && h < hac + hfp + hsy) ? hpol : 1 - hpol;
         e.vs  = (v >= vac + vfp && v < vac + vfp + vsy) ? vpol : 1 - vpol;
         e.ls  = (h == 0) ? 1 : 0;
         e.fs  = (h == 0 && v == 0) ? 1 : 0;
         if (h == ht - 1) begin
            h = 0;
            if (v == vt - 1) begin
               v  = 0;
               fc = (fc + 1) % (1 << fw);
            end else begin
               v++;
            end
         end else begin
            h++;
         end
         e.fc = fc;
      end else begin
         e.ls = 0;
         e.fs = 0;
      end
   endfunction

   task automatic compare_outputs();
      exp_t e;
      if (qa.size() == 0) check("a_queue_empty", 32'd1, 32'd0);
      else begin
         e = qa.pop_front();
         check("a_x", 32'(x_a), e.x);       check("a_y", 32'(y_a), e.y);
         check("a_hs", 32'(hs_a), e.hs);    check("a_vs", 32'(vs_a), e.vs);
         check("a_active", 32'(act_a), e.act);
         check("a_line_start", 32'(ls_a), e.ls);
         check("a_frame_start", 32'(fs_a), e.fs);
         check("a_frame_cnt", 32'(fc_a), e.fc);
      end
      if (qb.size() == 0) check("b_queue_empty", 32'd1, 32'd0);
      else begin
         e = qb.pop_front();
         check("b_x", 32'(x_b), e.x);       check("b_y", 32'(y_b), e.y);
         check("b_hs", 32'(hs_b), e.hs);    check("b_vs", 32'(vs_b), e.vs);
         check("b_active", 32'(act_b), e.act);
         check("b_line_start", 32'(ls_b), e.ls);
         check("b_frame_start", 32'(fs_b), e.fs);
         check("b_frame_cnt", 32'(fc_b), e.fc);
      end
   endtask

   initial begin
      bit rst_a_done, rst_b_done, prev_hs;
      int last_fall, last_fs, n_cont, n_alt, n_frames;
      rst_a_done = 0; rst_b_done = 0; prev_hs = 1;
      last_fall = -1; last_fs = -1; n_cont = 0; n_alt = 0; n_frames = 0;
      ha = 0; va = 0; fca = 0; hb = 0; vb = 0; fcb = 0;
      rst_a = 1'b1; pen_a = 1'b1; rst_b = 1'b1; pen_b = 1'b1;
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         if (c > 0) compare_outputs();

         // sync pulse width and period on the default-mode instance
         if (c == 20 || c == 2430) begin
            last_fall = -1;
            prev_hs   = hs_a;
         end else if ((c > 20 && c < 2410) || (c > 2430 && c < 6010)) begin
            if (prev_hs && !hs_a) begin
               if (last_fall >= 0) begin
                  check("a_hs_period", 32'(c - last_fall), (c < 2410) ? 800 : 1600);
                  if (c < 2410) n_cont++; else n_alt++;
               end
               last_fall = c;
            end else if (!prev_hs && hs_a && last_fall >= 0) begin
               check("a_hs_pulse", 32'(c - last_fall), (c < 2410) ? 96 : 192);
            end
            prev_hs = hs_a;
         end
         if (c > 10 && c < 250 && fs_b) begin
            if (last_fs >= 0) begin
               check("b_frame_len", 32'(c - last_fs), 32'd48);
               n_frames++;
            end
            last_fs = c;
         end

         pa = ea;
         pb = eb;
         if (c < 10)        begin rst_a = 1'b1; pen_a = 1'b1; end
         else if (c < 2410) begin rst_a = 1'b0; pen_a = 1'b1; end
         else if (c < 6010) begin rst_a = 1'b0; pen_a = 1'(c % 2); end
         else if (!rst_a_done && pa.x == 700 && pa.hs == 0) begin
            rst_a = 1'b1; pen_a = 1'b1; rst_a_done = 1;
         end else begin rst_a = 1'b0; pen_a = 1'b1; end

         if (c < 10)       begin rst_b = 1'b1; pen_b = 1'b1; end
         else if (c < 250) begin rst_b = 1'b0; pen_b = 1'b1; end
         else if (c < 400) begin
            if (!rst_b_done && pb.y == 4 && pb.x == 5 && pb.vs == 1 && pb.hs == 1) begin
               rst_b = 1'b1; rst_b_done = 1;
            end else rst_b = 1'b0;
            pen_b = 1'b1;
         end else if (c < 1200) begin rst_b = 1'b0; pen_b = 1'($urandom_range(0, 1)); end
         else begin rst_b = 1'b0; pen_b = 1'b1; end

         model_step(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8, rst_a, pen_a, ha, va, fca, ea);
         model_step(4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 2, rst_b, pen_b, hb, vb, fcb, eb);
         qa.push_back(ea);
         qb.push_back(eb);
      end
      @(negedge clk);
      compare_outputs();
      check("a_cont_periods_seen", 32'(n_cont >= 1), 32'd1);
      check("a_alt_periods_seen", 32'(n_alt >= 1), 32'd1);
      check("a_mid_reset_done", 32'(rst_a_done), 32'd1);
      check("b_mid_reset_done", 32'(rst_b_done), 32'd1);
      check("b_frames_seen", 32'(n_frames >= 4), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
